apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Shares the single APB master between NUM_REQ CPU-side requesters.
- Arbitrates round-robin, latches the winner's sel/addr/data, and drives the master's APBMASTERENABLE/CPUSEL/addr/data inputs.
- Holds the enable until the master returns CPUPREADY, then pulses a per-requester done.
- Sits between the CPU-side request sources and the APB master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, address width (matches master addr/PADDR).
- DATA_W, 21, write data width (matches master data/PWDATA).
- SEL_W, 8, CPUSEL code width.

Ports:
- PCLK  in  1  system clock, all state on rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request, level, held until req_done.
- req_sel  in  NUM_REQ*SEL_W  packed CPUSEL codes, requester i at [i*SEL_W +: SEL_W].
- req_addr  in  NUM_REQ*ADDR_W  packed addresses.
- req_data  in  NUM_REQ*DATA_W  packed write data.
- req_grant  out  NUM_REQ  one-hot, current owner, high for the whole transfer.
- req_done  out  NUM_REQ  one-cycle pulse to the owner on completion.
- mst_enable  out  1  to master APBMASTERENABLE.
- mst_cpusel  out  SEL_W  to master CPUSEL.
- mst_addr  out  ADDR_W  to master addr.
- mst_data  out  DATA_W  to master data.
- mst_cpuready  in  1  from master CPUPREADY.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr = NUM_REQ-1 (so requester 0 wins first). PRESET mid-transfer aborts immediately with no done pulse.
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - If any req_valid is set at the edge, pick the winner: the first set bit searching from rr_ptr+1 upward, with modulo-NUM_REQ wrap.
  - Register the winner's sel/addr/data into mst_*, set req_grant one-hot, set rr_ptr = winner, go to BUSY.
  - No req_valid: stay in IDLE; mst_* hold their last values.
- BUSY:
  - mst_enable = (state==BUSY) && !mst_cpuready. This is combinational, so the enable drops in the same cycle CPUPREADY rises and the master cannot relaunch from IDLE.
  - When mst_cpuready=1: pulse req_done[owner] for exactly that edge's next cycle, clear req_grant, go to DRAIN.
- DRAIN:
  - Wait for mst_cpuready==0, which the master clears in IDLE with enable low, then go to IDLE.
  - This state guarantees at least one cycle of enable low between transfers.
- Latency:
  - req_valid high in cycle 0 → grant/mst_* registered at edge 1 → mst_enable high in cycle 1.
  - Minimum request-to-done time is the master's IDLE→SETUP→ACCESS sequence plus 1 cycle.
- mst_* are stable for the whole of BUSY. Requester inputs are sampled only at the grant edge, so later changes are ignored.
- req_valid dropped during BUSY: the transfer still completes and req_done still pulses. The requester is responsible for ignoring it.
- req_valid dropped before grant: not served, nothing pending.
- A requester holding valid through its own done: it is not re-granted while others wait (round-robin); it is re-granted next if it is the sole requester.
- Simultaneous: req_valid rising in the same cycle as a done is considered only in the next IDLE.
- No queueing beyond one outstanding transfer. At most one req_grant bit is ever set.

Optional Feature:
- Macro APB_ARB_FIXED_PRIO_EN.
- Defined: the winner is the lowest-index asserted req_valid, and rr_ptr is unused (tied to reset value).
- Undefined (default): round-robin as above.
- All other timing is identical in both modes.

Test Plan:
- Single request: req_valid[2]=1, sel=8'h1, addr=8'h3C, data=21'h1ABCD.
  - mst_* equal those values from cycle 1, req_grant=4'b0100.
  - mst_enable stays high until CPUPREADY; the slave adds 3 PREADY wait cycles.
  - req_done[2] pulses exactly once, and mst_enable is low in the CPUPREADY cycle.
- Round-robin: all four req_valid held high.
  - Grant order is 0,1,2,3,0.
  - Each transfer separated by at least one DRAIN cycle with mst_enable=0.
  - Never two grant bits set.
- Wrap: rr_ptr=3 with req_valid=4'b1001 → requester 0 granted, then 3.
- Input change: requester 1 changes addr 8'h10→8'h20 during BUSY → mst_addr stays 8'h10 and done is still pulsed.
- Reset mid-transfer: PRESET asserted in BUSY.
  - Outputs 0 asynchronously and no req_done.
  - After release, requester 0 wins first.
- Fixed priority (APB_ARB_FIXED_PRIO_EN defined), req_valid=4'b1010 held → requester 1 served repeatedly and requester 3 starves. With the macro undefined, service alternates 1,3.

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
// Bundle between the CPU-side requesters, the arbiter and the shared APB master.
// slave  : the arbiter's view (takes requests, drives the master inputs).
// master : the surrounding logic's view (requesters plus the APB master).
// The parameters must match the ones given to apb_req_arbiter.
interface apb_req_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 21,
   parameter int SEL_W   = 8
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*SEL_W-1:0]  req_sel;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_grant;
   logic [NUM_REQ-1:0]        req_done;
   logic                      mst_enable;
   logic [SEL_W-1:0]          mst_cpusel;
   logic [ADDR_W-1:0]         mst_addr;
   logic [DATA_W-1:0]         mst_data;
   logic                      mst_cpuready;
   logic                      busy;

   modport slave (
      input  req_valid, req_sel, req_addr, req_data, mst_cpuready,
      output req_grant, req_done, mst_enable, mst_cpusel, mst_addr, mst_data, busy
   );

   modport master (
      output req_valid, req_sel, req_addr, req_data, mst_cpuready,
      input  req_grant, req_done, mst_enable, mst_cpusel, mst_addr, mst_data, busy
   );
endinterface

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one APB master between NUM_REQ requesters.
// Round-robin by default; define APB_ARB_FIXED_PRIO_EN for lowest-index-wins
// fixed priority (rr_ptr then stays at its reset value).
// IDLE -> BUSY on a grant, BUSY -> DRAIN on CPUPREADY, DRAIN -> IDLE once the
// master has dropped CPUPREADY, which guarantees an enable-low gap.
module apb_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 21,
   parameter int SEL_W   = 8
) (
   input  logic               PCLK,
   input  logic               PRESET,
   apb_req_arbiter_if.slave   bus
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

   state_t                          state, state_nxt;
   logic [PTR_W-1:0]                rr_ptr;
   logic [PTR_W-1:0]                win_idx;
   logic                            win_found;
   logic [NUM_REQ-1:0]              grant_q, done_q;
   logic [SEL_W-1:0]                cpusel_q;
   logic [ADDR_W-1:0]               addr_q;
   logic [DATA_W-1:0]               data_q;

   // per-requester views of the packed request fields
   logic [NUM_REQ-1:0][SEL_W-1:0]   sel_v;
   logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_v;
   logic [NUM_REQ-1:0][DATA_W-1:0]  data_v;

   assign sel_v  = bus.req_sel;
   assign addr_v = bus.req_addr;
   assign data_v = bus.req_data;

   // winner search; loops run from lowest to highest priority so the last hit wins
`ifdef APB_ARB_FIXED_PRIO_EN
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (bus.req_valid[PTR_W'(i)]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(i);
         end
      end
   end
`else
   logic [PTR_W-1:0] cand;
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (bus.req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end
`endif

   // state register
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_found)         state_nxt = BUSY;
         BUSY:    if (bus.mst_cpuready)  state_nxt = DRAIN;
         DRAIN:   if (!bus.mst_cpuready) state_nxt = IDLE;
         default:                        state_nxt = IDLE;
      endcase
   end

   // grant/done/master-input registers; request fields are sampled only at the grant edge
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         grant_q  <= '0;
         done_q   <= '0;
         cpusel_q <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         rr_ptr   <= PTR_W'(NUM_REQ-1);
      end else begin
         done_q <= '0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  grant_q  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                  cpusel_q <= sel_v[win_idx];
                  addr_q   <= addr_v[win_idx];
                  data_q   <= data_v[win_idx];
`ifndef APB_ARB_FIXED_PRIO_EN
                  rr_ptr   <= win_idx;
`endif
               end
            end
            BUSY: begin
               if (bus.mst_cpuready) begin
                  done_q  <= grant_q;
                  grant_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // enable drops combinationally with CPUPREADY so the master cannot relaunch
   assign bus.mst_enable = (state == BUSY) && !bus.mst_cpuready;
   assign bus.busy       = (state != IDLE);
   assign bus.req_grant  = grant_q;
   assign bus.req_done   = done_q;
   assign bus.mst_cpusel = cpusel_q;
   assign bus.mst_addr   = addr_q;
   assign bus.mst_data   = data_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: stimulus pushes the expected completion,
// a monitor pops and compares on every req_done pulse. A small APB master model
// answers enable with CPUPREADY after SETUP+ACCESS+3 wait cycles.
module tb_apb_req_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 21;
   localparam int SEL_W   = 8;
   localparam int LAT     = 5;

   typedef struct {
      logic [NUM_REQ-1:0] done;
      logic [SEL_W-1:0]   sel;
      logic [ADDR_W-1:0]  addr;
      logic [DATA_W-1:0]  data;
   } exp_t;

   logic PCLK = 1'b0;
   logic PRESET = 1'b1;
   always #5 PCLK = ~PCLK;

   apb_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus();

   apb_req_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .bus    (bus.slave)
   );

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   logic [SEL_W-1:0]  sel_t [NUM_REQ] = '{8'hA0, 8'hA1, 8'h01, 8'hA3};
   logic [ADDR_W-1:0] addr_t[NUM_REQ] = '{8'h00, 8'h10, 8'h3C, 8'hF0};
   logic [DATA_W-1:0] data_t[NUM_REQ] = '{21'h00111, 21'h02222, 21'h1ABCD, 21'h1FFFF};

`ifdef APB_ARB_FIXED_PRIO_EN
   int wrap_ord[2] = '{0, 0};
   int rr_ord[5]   = '{0, 0, 0, 0, 0};
   int alt_ord[4]  = '{1, 1, 1, 1};
`else
   int wrap_ord[2] = '{0, 3};
   int rr_ord[5]   = '{0, 1, 2, 3, 0};
   int alt_ord[4]  = '{1, 3, 1, 3};
`endif

   task automatic drive_tables();
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_sel [i*SEL_W  +: SEL_W]  = sel_t[i];
         bus.req_addr[i*ADDR_W +: ADDR_W] = addr_t[i];
         bus.req_data[i*DATA_W +: DATA_W] = data_t[i];
      end
   endtask

   function automatic exp_t mk(input int i);
      exp_t e;
      logic [NUM_REQ-1:0] one;
      one    = 1;
      e.done = one << i;
      e.sel  = sel_t[i];
      e.addr = addr_t[i];
      e.data = data_t[i];
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_dones(input int target);
      int n;
      n = 0;
      while (done_cnt < target && n < 300) begin
         @(negedge PCLK); #2;
         n++;
      end
      chk("done_timeout", 32'(done_cnt >= target), 32'd1);
   endtask

   task automatic held(input logic [NUM_REQ-1:0] mask, input int n);
      int base;
      base = done_cnt;
      bus.req_valid = mask;
      wait_dones(base + n);
      bus.req_valid = '0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(negedge PCLK); #2; end
   endtask

   // APB master model: counts enable cycles, raises CPUPREADY, clears it once back in IDLE
   initial begin
      int cnt;
      cnt = 0;
      bus.mst_cpuready = 1'b0;
      forever begin
         @(negedge PCLK);
         if (PRESET) begin
            cnt = 0;
            bus.mst_cpuready = 1'b0;
         end else if (bus.mst_cpuready) begin
            if (!bus.mst_enable) bus.mst_cpuready = 1'b0;
         end else if (bus.mst_enable) begin
            cnt++;
            if (cnt == LAT) begin
               bus.mst_cpuready = 1'b1;
               cnt = 0;
            end
         end
      end
   end

   // monitor: grant invariant every cycle, scoreboard compare on each done pulse
   initial begin
      exp_t e;
      forever begin
         @(negedge PCLK); #1;
         if (!PRESET) begin
            checks++;
            if (!$onehot0(bus.req_grant)) begin
               errors++;
               $display("FAIL grant_onehot: got %b", bus.req_grant);
            end
            if (bus.req_done != '0) begin
               done_cnt++;
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_done: got done=%b with nothing expected", bus.req_done);
               end else begin
                  e = sb.pop_front();
                  if (bus.req_done !== e.done || bus.mst_cpusel !== e.sel ||
                      bus.mst_addr !== e.addr || bus.mst_data !== e.data) begin
                     errors++;
                     $display("FAIL done_payload: got done=%b sel=%h addr=%h data=%h expected done=%b sel=%h addr=%h data=%h",
                              bus.req_done, bus.mst_cpusel, bus.mst_addr, bus.mst_data,
                              e.done, e.sel, e.addr, e.data);
                  end
                  checks++;
                  if (bus.mst_enable !== 1'b0 || bus.req_grant !== '0 || bus.busy !== 1'b1) begin
                     errors++;
                     $display("FAIL drain_state: got en=%b grant=%b busy=%b expected en=0 grant=0 busy=1",
                              bus.mst_enable, bus.req_grant, bus.busy);
                  end
               end
            end
         end
      end
   end

   initial begin
      int cycles, base;
      bus.req_valid = '0;
      drive_tables();

      // reset state
      idle_cycles(2);
      chk("rst_outputs", 32'({bus.req_grant, bus.req_done, bus.mst_enable, bus.busy}), 32'd0);
      chk("rst_mst_addr", 32'(bus.mst_addr), 32'd0);
      chk("rst_mst_data", 32'(bus.mst_data), 32'd0);
      chk("rst_mst_sel", 32'(bus.mst_cpusel), 32'd0);
      PRESET = 1'b0;
      idle_cycles(1);

      // single request, latency and enable shape
      base = done_cnt;
      sb.push_back(mk(2));
      bus.req_valid = 4'b0100;
      idle_cycles(1);
      cycles = 1;
      chk("single_grant", 32'(bus.req_grant), 32'h4);
      chk("single_enable", 32'(bus.mst_enable), 32'd1);
      chk("single_sel", 32'(bus.mst_cpusel), 32'h01);
      chk("single_addr", 32'(bus.mst_addr), 32'h3C);
      chk("single_data", 32'(bus.mst_data), 32'h1ABCD);
      while (done_cnt == base && cycles < 50) begin
         if (bus.mst_cpuready) chk("enable_low_in_ready", 32'(bus.mst_enable), 32'd0);
         else                  chk("enable_held", 32'(bus.mst_enable), 32'd1);
         idle_cycles(1);
         cycles++;
      end
      chk("done_latency", 32'(cycles), 32'd6);
      bus.req_valid = '0;
      idle_cycles(3);

      // requester 3 alone moves rr_ptr to 3
      sb.push_back(mk(3));
      held(4'b1000, 1);
      idle_cycles(3);

      // wrap from rr_ptr=3
      for (int i = 0; i < 2; i++) sb.push_back(mk(wrap_ord[i]));
      held(4'b1001, 2);
      idle_cycles(3);

      // all four held
      for (int i = 0; i < 5; i++) sb.push_back(mk(rr_ord[i]));
      held(4'b1111, 5);
      idle_cycles(3);

      // input change and valid drop during BUSY
      base = done_cnt;
      sb.push_back(mk(1));
      bus.req_valid = 4'b0010;
      idle_cycles(1);
      chk("chg_grant", 32'(bus.req_grant), 32'h2);
      addr_t[1] = 8'h20;
      drive_tables();
      bus.req_valid = '0;
      idle_cycles(1);
      chk("chg_addr_held", 32'(bus.mst_addr), 32'h10);
      wait_dones(base + 1);
      addr_t[1] = 8'h10;
      drive_tables();
      idle_cycles(3);

      // reset mid-transfer
      bus.req_valid = 4'b0100;
      idle_cycles(2);
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      PRESET = 1'b1;
      #1;
      chk("async_rst_ctl", 32'({bus.req_grant, bus.req_done, bus.mst_enable, bus.busy}), 32'd0);
      chk("async_rst_addr", 32'(bus.mst_addr), 32'd0);
      bus.req_valid = '0;
      idle_cycles(1);
      PRESET = 1'b0;
      idle_cycles(1);
      sb.push_back(mk(0));
      held(4'b1101, 1);
      idle_cycles(3);

      // 1 and 3 competing
      for (int i = 0; i < 4; i++) sb.push_back(mk(alt_ord[i]));
      held(4'b1010, 4);
      idle_cycles(5);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
